name_entry_ctrl: RTL and testbench

NAME_ENTRY_CTRL -- requirements
Module: name_entry_ctrl

---
 rtl/name_entry_ctrl.sv | 172 +++++++++++++++++
 tb/tb_name_entry_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/name_entry_ctrl.sv
// Three-letter name entry for the scoreboard scene: cursor moves, up/down
// character stepping with auto-repeat, and a confirm-to-commit lock.
module name_entry_ctrl #(
    parameter int REPEAT_DELAY     = 30,
    parameter int REPEAT_RATE      = 8,
    parameter int CHAR_MAX         = 25,
    parameter int STATE_SIZE       = 3,
    parameter int SCENE_SCOREBOARD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STATE_SIZE-1:0] state,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_confirm,
    output logic [1:0]            input_pos,
    output logic [14:0]           player_name,
    output logic                  name_done,
    output logic                  name_locked
);
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0]      DELAY_C    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0]      RELOAD_C   = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [4:0]            CHAR_MAX_C = 5'(CHAR_MAX);
    localparam logic [STATE_SIZE-1:0] SCENE_C    = STATE_SIZE'(SCENE_SCOREBOARD);

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        LOCKED = 2'd2
    } fsm_t;

    fsm_t             fsm_q;
    logic [4:0]       btn_lvl;
    logic [4:0]       btn_q;
    logic [4:0]       btn_rise;
    logic [4:0]       btn_ev;
    logic [1:0]       rpt_ev;
    logic             in_scene;
    logic             in_edit;
    logic [1:0]       pos_q;
    logic [14:0]      name_q;
    logic [14:0]      name_d;
    logic             done_q;
    logic             locked_q;
    logic [2:0][4:0]  slot_q;
    logic [2:0][4:0]  slot_d;

    assign btn_lvl  = {btn_confirm, btn_down, btn_up, btn_right, btn_left};
    assign in_scene = (state == SCENE_C);
    assign in_edit  = (fsm_q == EDIT);
    assign btn_rise = btn_lvl & ~btn_q;
    assign btn_ev   = in_edit ? (btn_rise | {1'b0, rpt_ev, 2'b00}) : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_lvl;
        end
    end

    // Up/down repeat: counter starts at 0 the cycle after a press made in EDIT,
    // so the first repeat fires once the press is followed by REPEAT_DELAY held cycles.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
            logic             arm_q;
            logic [CNT_W-1:0] cnt_q;

            assign rpt_ev[gi] = arm_q && btn_lvl[BTN_U + gi] && (cnt_q == DELAY_C);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    arm_q <= 1'b0;
                    cnt_q <= '0;
                end else if (!in_edit || !btn_lvl[BTN_U + gi]) begin
                    arm_q <= 1'b0;
                    cnt_q <= '0;
                end else if (btn_rise[BTN_U + gi]) begin
                    arm_q <= 1'b1;
                    cnt_q <= '0;
                end else if (arm_q) begin
                    cnt_q <= (cnt_q == DELAY_C) ? RELOAD_C : cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    // Per-slot next character; only the slot under the cursor can change.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            logic [4:0] inc_c;
            logic [4:0] dec_c;

            assign slot_q[gi] = name_q[14 - 5*gi -: 5];
            assign inc_c = (slot_q[gi] >= CHAR_MAX_C) ? 5'd0 : slot_q[gi] + 5'd1;
            assign dec_c = (slot_q[gi] == 5'd0 || slot_q[gi] > CHAR_MAX_C) ? CHAR_MAX_C
                                                                            : slot_q[gi] - 5'd1;
            assign slot_d[gi] = (pos_q != 2'(gi)) ? slot_q[gi] :
                                btn_ev[BTN_U]     ? inc_c      : dec_c;
        end
    endgenerate

    assign name_d = {slot_d[0], slot_d[1], slot_d[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            pos_q    <= 2'd0;
            name_q   <= '0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (in_scene) begin
                        fsm_q  <= EDIT;
                        name_q <= '0;
                        pos_q  <= 2'd0;
                    end
                end
                EDIT: begin
                    if (!in_scene) begin
                        fsm_q    <= IDLE;
                        pos_q    <= 2'd0;
                        locked_q <= 1'b0;
                    end else if (btn_ev[BTN_C]) begin
                        if (pos_q == 2'd3) begin
                            fsm_q    <= LOCKED;
                            done_q   <= 1'b1;
                            locked_q <= 1'b1;
                        end else begin
                            pos_q <= pos_q + 2'd1;
                        end
                    end else if (btn_ev[BTN_L] || btn_ev[BTN_R]) begin
                        // Opposing moves cancel and also swallow any up/down this cycle.
                        if (btn_ev[BTN_L] ^ btn_ev[BTN_R]) begin
                            pos_q <= btn_ev[BTN_L] ? pos_q - 2'd1 : pos_q + 2'd1;
                        end
                    end else if ((btn_ev[BTN_U] ^ btn_ev[BTN_D]) && (pos_q != 2'd3)) begin
                        name_q <= name_d;
                    end
                end
                LOCKED: begin
                    if (!in_scene) begin
                        fsm_q    <= IDLE;
                        pos_q    <= 2'd0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign input_pos   = pos_q;
    assign player_name = name_q;
    assign name_done   = done_q;
    assign name_locked = locked_q;

endmodule

// File: tb/tb_name_entry_ctrl.sv
// Bench for name_entry_ctrl: directed scenarios with literal expectations plus
// randomized button traffic, all checked every cycle against a behavioural model.
module tb_name_entry_ctrl;
    localparam int D     = 30;
    localparam int R     = 8;
    localparam int CMAX  = 25;
    localparam int SCENE = 4;

    localparam logic [4:0] ML = 5'b00001;
    localparam logic [4:0] MR = 5'b00010;
    localparam logic [4:0] MU = 5'b00100;
    localparam logic [4:0] MD = 5'b01000;
    localparam logic [4:0] MC = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  state = 3'd0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_confirm = 1'b0;
    logic [1:0]  input_pos;
    logic [14:0] player_name;
    logic        name_done;
    logic        name_locked;

    int n_checks = 0;
    int n_fail = 0;

    name_entry_ctrl #(
        .REPEAT_DELAY(D),
        .REPEAT_RATE(R),
        .CHAR_MAX(CMAX),
        .STATE_SIZE(3),
        .SCENE_SCOREBOARD(SCENE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .state(state),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_confirm(btn_confirm),
        .input_pos(input_pos),
        .player_name(player_name),
        .name_done(name_done),
        .name_locked(name_locked)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = idle, 1 = editing, 2 = locked.
    int m_mode = 0;
    int m_pos = 0;
    int m_ch[3] = '{0, 0, 0};
    int m_done = 0;
    int m_locked = 0;
    int m_prev[5] = '{0, 0, 0, 0, 0};
    int m_held[2] = '{-1, -1};  // cycles since an in-edit press, -1 when not tracking

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_done = 0; m_locked = 0;
        for (int i = 0; i < 3; i++) m_ch[i] = 0;
        for (int i = 0; i < 5; i++) m_prev[i] = 0;
        m_held[0] = -1; m_held[1] = -1;
    endtask

    task automatic model_step();
        int lvl[5];
        int ev[5];
        int scene;
        int edit;
        int h;
        lvl[0] = int'(btn_left); lvl[1] = int'(btn_right); lvl[2] = int'(btn_up);
        lvl[3] = int'(btn_down); lvl[4] = int'(btn_confirm);
        scene = (int'(state) == SCENE) ? 1 : 0;
        edit  = (m_mode == 1) ? 1 : 0;
        for (int i = 0; i < 5; i++) ev[i] = (edit == 1 && lvl[i] == 1 && m_prev[i] == 0) ? 1 : 0;
        for (int j = 0; j < 2; j++) begin
            if (edit == 0 || lvl[2+j] == 0) h = -1;
            else if (m_prev[2+j] == 0) h = 0;
            else if (m_held[j] >= 0) h = m_held[j] + 1;
            else h = -1;
            if (h > D && ((h - D - 1) % R) == 0) ev[2+j] = 1;
            m_held[j] = h;
        end
        m_done = 0;
        if (m_mode == 0) begin
            if (scene == 1) begin
                m_mode = 1; m_pos = 0;
                for (int i = 0; i < 3; i++) m_ch[i] = 0;
            end
        end else if (scene == 0) begin
            m_mode = 0; m_pos = 0; m_locked = 0;
        end else if (m_mode == 1) begin
            if (ev[4] == 1) begin
                if (m_pos == 3) begin
                    m_mode = 2; m_done = 1; m_locked = 1;
                end else begin
                    m_pos = m_pos + 1;
                end
            end else if (ev[0] == 1 || ev[1] == 1) begin
                if (ev[0] != ev[1]) m_pos = (m_pos + ((ev[0] == 1) ? 3 : 1)) % 4;
            end else if (ev[2] != ev[3] && m_pos < 3) begin
                if (ev[2] == 1) m_ch[m_pos] = (m_ch[m_pos] + 1) % (CMAX + 1);
                else m_ch[m_pos] = (m_ch[m_pos] + CMAX) % (CMAX + 1);
            end
        end
        for (int i = 0; i < 5; i++) m_prev[i] = lvl[i];
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_pos", int'(input_pos), m_pos);
            chk("model_name", int'(player_name), m_ch[0] * 1024 + m_ch[1] * 32 + m_ch[2]);
            chk("model_done", int'(name_done), m_done);
            chk("model_locked", int'(name_locked), m_locked);
        end
    end

    task automatic set_btns(input logic [4:0] m);
        btn_left = m[0]; btn_right = m[1]; btn_up = m[2]; btn_down = m[3]; btn_confirm = m[4];
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m);
        set_btns(m);
        cyc(1);
        set_btns(5'd0);
        cyc(1);
        $display("press %b -> pos=%0d name=%h done=%0d locked=%0d",
                 m, input_pos, player_name, name_done, name_locked);
    endtask

    task automatic hold(input logic [4:0] m, input int n);
        set_btns(m);
        cyc(n);
        set_btns(5'd0);
        cyc(1);
        $display("hold %b for %0d -> pos=%0d name=%h", m, n, input_pos, player_name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"}, int'(input_pos), 0);
        chk({tag, "_name"}, int'(player_name), 0);
        chk({tag, "_done"}, int'(name_done), 0);
        chk({tag, "_locked"}, int'(name_locked), 0);
    endtask

    initial begin
        int nb;
        logic [4:0] m;
        int len;

        #1 rst_n = 1'b0;
        #1 chk_all_zero("por");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_pos", int'(input_pos), 0);

        state = 3'(SCENE);
        cyc(1);
        $display("enter scene -> pos=%0d name=%h", input_pos, player_name);
        chk("enter_name", int'(player_name), 0);

        press(MU); press(MU); press(MR); press(MD); press(MC); press(MC);
        chk("cza_name", int'(player_name), 2 * 1024 + 25 * 32 + 0);
        chk("cza_pos", int'(input_pos), 3);

        set_btns(MC);
        cyc(1);
        chk("commit_done", int'(name_done), 1);
        chk("commit_locked", int'(name_locked), 1);
        set_btns(5'd0);
        cyc(1);
        $display("commit -> done=%0d locked=%0d", name_done, name_locked);
        chk("commit_done_drop", int'(name_done), 0);

        press(MU); press(ML);
        chk("locked_name", int'(player_name), 2848);
        chk("locked_pos", int'(input_pos), 3);

        state = 3'd0;
        cyc(1);
        $display("leave scene -> pos=%0d locked=%0d", input_pos, name_locked);
        chk("leave_locked", int'(name_locked), 0);
        chk("leave_pos", int'(input_pos), 0);
        chk("leave_name_hold", int'(player_name), 2848);

        state = 3'(SCENE);
        cyc(1);
        chk("reenter_name", int'(player_name), 0);

        hold(MU, D + 2 * R + 1);
        chk("repeat_ch0", int'(player_name[14:10]), 3);
        repeat (21) press(MU);
        chk("ch0_24", int'(player_name[14:10]), 24);
        hold(MU, D + 2 * R + 1);
        chk("repeat_wrap_ch0", int'(player_name[14:10]), 1);

        press(ML);      chk("left_wrap", int'(input_pos), 3);
        press(MR);      chk("right_wrap", int'(input_pos), 0);
        press(ML | MR); chk("lr_cancel", int'(input_pos), 0);
        press(ML | MR | MU);
        chk("lru_pos", int'(input_pos), 0);
        chk("lru_ch0", int'(player_name[14:10]), 1);
        press(MC | MU);
        chk("cu_pos", int'(input_pos), 1);
        chk("cu_ch0", int'(player_name[14:10]), 1);
        press(ML);
        press(MU | MD); chk("ud_cancel", int'(player_name[14:10]), 1);
        press(MD); press(MD);
        chk("down_wrap", int'(player_name[14:10]), 25);
        press(ML);
        press(MU);      chk("up_at_3", int'(player_name), 25 * 1024);
        press(MR);

        state = 3'd0;
        cyc(2);
        set_btns(MU);
        cyc(2);
        state = 3'(SCENE);
        cyc(D + 2 * R + 5);
        chk("held_entry", int'(player_name), 0);
        set_btns(5'd0);
        cyc(1);
        press(MU);
        chk("held_repress", int'(player_name[14:10]), 1);
        press(MR);
        state = 3'd0;
        cyc(1);
        chk("leave2_pos", int'(input_pos), 0);
        chk("leave2_locked", int'(name_locked), 0);

        state = 3'(SCENE);
        cyc(1);
        press(MU); press(MR);
        set_btns(MU);
        cyc(10);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        $display("async reset mid-hold -> pos=%0d name=%h", input_pos, player_name);
        @(negedge clk);
        set_btns(5'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_name", int'(player_name), 0);
        press(MU);
        chk("post_rst_edit", int'(player_name[14:10]), 1);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 99) < 2) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            state = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(0, 7)) : 3'(SCENE);
            m = 5'd0;
            nb = $urandom_range(0, 99);
            if (nb < 20) m[0] = 1'b1;
            if ($urandom_range(0, 99) < 20) m[1] = 1'b1;
            if ($urandom_range(0, 99) < 30) m[2] = 1'b1;
            if ($urandom_range(0, 99) < 25) m[3] = 1'b1;
            if ($urandom_range(0, 99) < 12) m[4] = 1'b1;
            len = ($urandom_range(0, 99) < 15) ? $urandom_range(5, 60) : $urandom_range(1, 3);
            set_btns(m);
            cyc(len);
            set_btns(5'd0);
            cyc($urandom_range(1, 3));
            $display("txn %0d: btn=%b state=%0d len=%0d -> pos=%0d name=%h done=%0d locked=%0d",
                     t, m, state, len, input_pos, player_name, name_done, name_locked);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
